// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic sensor front end and the light controller.
//   emerg_state_t  : emergency confirm/hold FSM states
//   N_IR, N_LANES  : sensor counts
//   RED/YELLOW/GREEN : light encodings used by the controller
//   lowest_onehot  : isolates the lowest set bit of a lane vector
//   popcount_ir    : number of set bits in an IR vector (fits 4 bits for 12 sensors)
package traffic_pkg;

  localparam int N_IR    = 12;
  localparam int N_LANES = 4;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    ACTIVE  = 2'd2,
    HOLD    = 2'd3
  } emerg_state_t;

  // Scan from the top down so the lowest set index is the one left standing.
  function automatic logic [N_LANES-1:0] lowest_onehot(input logic [N_LANES-1:0] v);
    logic [N_LANES-1:0] res;
    res = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (v[i]) begin
        res    = '0;
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] popcount_ir(input logic [N_IR-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_IR; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One-bit synchroniser plus debouncer.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_raw          : raw input, asynchronous to i_clk
//   o_clean        : debounced level
// A change is accepted after DEB_CYCLES consecutive synchronised samples that
// differ from the current clean level; any agreeing sample restarts the count.
// Raw edge to o_clean change takes 2 + DEB_CYCLES clock edges.
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_clean
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_clean;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_clean <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_clean) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        // This edge is the DEB_CYCLES-th differing sample.
        r_clean <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_clean = r_clean;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Front-end conditioning stage for the traffic light controller.
// Optional feature macro: TRAFFIC_STUCK_DETECT_EN (IR stuck-high detection).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   IR_sensors        : raw IR occupancy bits
//   sound_sensors     : raw siren detector bits, one per lane
//   ir_clean          : debounced IR vector
//   density           : occupied (non-stuck) sensor count, updated at window end
//   high_density      : density >= HIGH_THRESH, updated with density
//   window_valid      : one-cycle pulse in the cycle density/high_density update
//   emergency         : emergency granted (FSM in ACTIVE or HOLD)
//   emergency_lanes   : one-hot granted lane, 0 when emergency is low
//   stuck_mask        : IR sensors excluded as stuck high (0 without the macro)
//   o_dbg_state       : current emergency FSM state
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int WINDOW      = 16,
  parameter int HIGH_THRESH = 8,
  parameter int EMERG_CONF  = 3,
  parameter int EMERG_HOLD  = 8
`ifdef TRAFFIC_STUCK_DETECT_EN
  , parameter int STUCK_LIMIT = 1024
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_IR-1:0]    IR_sensors,
  input  logic [N_LANES-1:0] sound_sensors,
  output logic [N_IR-1:0]    ir_clean,
  output logic [3:0]         density,
  output logic               high_density,
  output logic               window_valid,
  output logic               emergency,
  output logic [N_LANES-1:0] emergency_lanes,
  output logic [N_IR-1:0]    stuck_mask,
  output emerg_state_t       o_dbg_state
);

  localparam int NS   = N_IR + N_LANES;
  localparam int WW   = $clog2(WINDOW);
  localparam int EMAX = (EMERG_CONF > EMERG_HOLD) ? EMERG_CONF : EMERG_HOLD;
  localparam int ECW  = $clog2(EMAX + 1);

  // Sync + debounce for every raw input; IR in the low bits, sound on top.
  logic [NS-1:0]      w_raw;
  logic [NS-1:0]      w_clean;
  logic [N_IR-1:0]    w_ir_clean;
  logic [N_LANES-1:0] w_snd;

  assign w_raw = {sound_sensors, IR_sensors};

  for (genvar g = 0; g < NS; g++) begin : g_deb
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (clk),
      .i_reset (reset),
      .i_raw   (w_raw[g]),
      .o_clean (w_clean[g])
    );
  end

  assign w_ir_clean = w_clean[N_IR-1:0];
  assign w_snd      = w_clean[NS-1:N_IR];

  // Stuck-high detection.
  logic [N_IR-1:0] w_stuck;

`ifdef TRAFFIC_STUCK_DETECT_EN
  localparam int SW = $clog2(STUCK_LIMIT + 1);

  for (genvar g = 0; g < N_IR; g++) begin : g_stuck
    logic [SW-1:0] r_high_cnt;

    // Counter saturates at STUCK_LIMIT; the mask is that saturated state, so it
    // drops on the edge after the clean bit falls.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_high_cnt <= '0;
      end else if (!w_ir_clean[g]) begin
        r_high_cnt <= '0;
      end else if (r_high_cnt != SW'(STUCK_LIMIT)) begin
        r_high_cnt <= r_high_cnt + 1'b1;
      end
    end

    assign w_stuck[g] = (r_high_cnt == SW'(STUCK_LIMIT));
  end
`else
  assign w_stuck = '0;
`endif

  // Windowed density.
  logic [WW-1:0] r_win;
  logic [3:0]    r_density;
  logic          r_high;
  logic          r_valid;
  logic [3:0]    w_count;

  assign w_count = popcount_ir(w_ir_clean & ~w_stuck);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_win     <= '0;
      r_density <= '0;
      r_high    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_win == WW'(WINDOW - 1)) begin
        r_win     <= '0;
        r_density <= w_count;
        r_high    <= (int'(w_count) >= HIGH_THRESH);
        r_valid   <= 1'b1;
      end else begin
        r_win <= r_win + 1'b1;
      end
    end
  end

  // Emergency confirm/hold FSM. r_ecnt is shared: confirm run length in
  // CONFIRM, elapsed hold cycles in HOLD.
  emerg_state_t       r_state;
  emerg_state_t       w_next;
  logic [N_LANES-1:0] r_lane;
  logic [N_LANES-1:0] w_lane_next;
  logic [ECW-1:0]     r_ecnt;
  logic [ECW-1:0]     w_ecnt_next;
  logic               w_lane_on;
  logic               w_grant;
  logic               r_emerg;
  logic [N_LANES-1:0] r_lanes;

  assign w_lane_on = |(w_snd & r_lane);

  always_comb begin
    w_next      = r_state;
    w_lane_next = r_lane;
    w_ecnt_next = r_ecnt;
    case (r_state)
      IDLE: begin
        if (|w_snd) begin
          w_next      = CONFIRM;
          w_lane_next = lowest_onehot(w_snd);
          w_ecnt_next = '0;
        end
      end
      CONFIRM: begin
        if (!w_lane_on) begin
          w_next      = IDLE;
          w_lane_next = '0;
          w_ecnt_next = '0;
        end else if (r_ecnt == ECW'(EMERG_CONF - 1)) begin
          w_next      = ACTIVE;
          w_ecnt_next = '0;
        end else begin
          w_ecnt_next = r_ecnt + 1'b1;
        end
      end
      ACTIVE: begin
        // Other lanes are deliberately ignored while a lane is granted.
        if (!w_lane_on) begin
          w_next      = HOLD;
          w_ecnt_next = '0;
        end
      end
      HOLD: begin
        if (w_lane_on) begin
          w_next      = ACTIVE;
          w_ecnt_next = '0;
        end else if (r_ecnt == ECW'(EMERG_HOLD - 1)) begin
          w_next      = IDLE;
          w_lane_next = '0;
          w_ecnt_next = '0;
        end else begin
          w_ecnt_next = r_ecnt + 1'b1;
        end
      end
      default: begin
        w_next      = IDLE;
        w_lane_next = '0;
        w_ecnt_next = '0;
      end
    endcase
    w_grant = (w_next == ACTIVE) || (w_next == HOLD);
  end

  // Outputs registered from the next state so emergency rises on the very
  // edge that enters ACTIVE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_lane  <= '0;
      r_ecnt  <= '0;
      r_emerg <= 1'b0;
      r_lanes <= '0;
    end else begin
      r_state <= w_next;
      r_lane  <= w_lane_next;
      r_ecnt  <= w_ecnt_next;
      r_emerg <= w_grant;
      r_lanes <= w_grant ? w_lane_next : '0;
    end
  end

  assign ir_clean        = w_ir_clean;
  assign density         = r_density;
  assign high_density    = r_high;
  assign window_valid    = r_valid;
  assign emergency       = r_emerg;
  assign emergency_lanes = r_lanes;
  assign stuck_mask      = w_stuck;
  assign o_dbg_state     = r_state;

endmodule
